// File: rtl/p251_vec_sub_pkg.sv
// Shared constants for the GF(251) vector datapath: field modulus, element width
// and the controller state encoding.
package p251_vec_sub_pkg;

  localparam int P251_Q = 251;
  localparam int P251_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/p251_vec_sub_if.sv
// Start/done handshake plus operand-RAM read port and result-RAM write port.
interface p251_vec_sub_if #(
  parameter int ADDR_W = 4
);

  logic              i_start;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [7:0]        in_1;
  logic [7:0]        in_2;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        out;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, in_1, in_2,
    output o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, out, o_busy, o_done
  );

  modport master (
    output i_start, in_1, in_2,
    input  o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, out, o_busy, o_done
  );

endinterface

// File: rtl/p251_sub_core.sv
// Combinational a - b mod 251. Operands may be non-canonical (251..255) and are
// folded once before the subtraction, so the result is always in 0..250.
module p251_sub_core
  import p251_vec_sub_pkg::*;
(
  input  logic [P251_W-1:0] a,
  input  logic [P251_W-1:0] b,
  output logic [P251_W-1:0] r
);

  localparam logic [P251_W-1:0] Q8 = P251_W'(P251_Q);

  function automatic logic [P251_W-1:0] fold(input logic [P251_W-1:0] v);
    return (v >= Q8) ? v - Q8 : v;
  endfunction

  // A negative 9-bit difference lies in -250..-1; one add of q makes it canonical.
  function automatic logic [P251_W-1:0] wrap(input logic signed [P251_W:0] diff);
    logic signed [P251_W:0] t;
    t = diff[P251_W] ? diff + $signed({1'b0, Q8}) : diff;
    return t[P251_W-1:0];
  endfunction

  logic [P251_W-1:0]      x;
  logic [P251_W-1:0]      y;
  logic signed [P251_W:0] d;

  always_comb begin
    x = fold(a);
    y = fold(b);
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    r = wrap(d);
  end

endmodule

// File: rtl/p251_vec_sub.sv
// Streaming GF(251) vector subtractor: reads in_1/in_2 from synchronous RAMs and
// writes (in_1 - in_2) mod 251 to a result RAM, under a start/done handshake.
module p251_vec_sub
  import p251_vec_sub_pkg::*;
#(
  parameter int N_ELEM = 16,
  parameter int ADDR_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  p251_vec_sub_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ELEM - 1);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(1);

  state_t            state;
  logic              vld_p0;
  logic [P251_W-1:0] res_p0;

  p251_sub_core u_core (
    .a (bus.in_1),
    .b (bus.in_2),
    .r (res_p0)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      vld_p0        <= 1'b0;
      bus.o_rd_en   <= 1'b0;
      bus.o_rd_addr <= '0;
      bus.o_wr_en   <= 1'b0;
      bus.o_wr_addr <= '0;
      bus.out       <= '0;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
    end else begin
      // p0: RAM data returns one cycle after the read strobe
      vld_p0 <= bus.o_rd_en;

      // p1: register the result and issue the write
      bus.o_wr_en <= vld_p0;
      if (vld_p0) begin
        bus.out <= res_p0;
      end
      if (vld_p0 && bus.o_wr_en && (bus.o_wr_addr != LAST)) begin
        bus.o_wr_addr <= bus.o_wr_addr + INC;
      end

      bus.o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state         <= S_READ;
            bus.o_rd_en   <= 1'b1;
            bus.o_rd_addr <= '0;
            bus.o_wr_addr <= '0;
            bus.o_busy    <= 1'b1;
          end
        end
        S_READ: begin
          if (bus.o_rd_addr == LAST) begin
            bus.o_rd_en <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            bus.o_rd_addr <= bus.o_rd_addr + INC;
          end
        end
        S_DRAIN: begin
          // The final write is the one with no further valid data behind it.
          if (bus.o_wr_en && !vld_p0) begin
            state      <= S_DONE;
            bus.o_done <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/p251_vec_sub.md
Name: p251_vec_sub

Overview:
- Streaming vector subtractor over GF(251): for k = 0..N_ELEM-1 computes out[k] = (in_1[k] - in_2[k]) mod 251.
- Inverse-direction companion to the modular adder; used in SDitH share/MPC computations, e.g. recovering masked values and forming differences.
- Reads both operand vectors from external synchronous RAMs, then writes results to a result RAM through an address/enable interface.
- Controlled by a start/done handshake.

Parameters:
- N_ELEM, 16: vector length in elements; legal range 1..2^ADDR_W.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W >= N_ELEM.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: synchronous reset, active-high.
- i_start, input, 1: single-cycle start pulse; sampled only in IDLE.
- o_rd_en, output, 1: read enable to both operand RAMs.
- o_rd_addr, output, ADDR_W: read address shared by both operand RAMs.
- in_1, input, 8: minuend RAM data; valid 1 cycle after o_rd_en.
- in_2, input, 8: subtrahend RAM data; valid 1 cycle after o_rd_en.
- o_wr_en, output, 1: result RAM write enable.
- o_wr_addr, output, ADDR_W: result RAM write address.
- out, output, 8: result data, always in 0..250.
- o_busy, output, 1: high from the cycle after an accepted start until the o_done cycle, inclusive.
- o_done, output, 1: single-cycle completion pulse.

Behaviour:
- Single clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: o_rd_en=0, o_rd_addr=0, o_wr_en=0, o_wr_addr=0, out=0, o_busy=0, o_done=0. FSM returns to IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on i_start.
  - READ -> DRAIN after issuing address N_ELEM-1.
  - DRAIN -> DONE once the last write has been issued.
  - DONE -> IDLE unconditionally.
- Timing, with the start cycle = cycle 0:
  - o_rd_en=1 in cycles 1..N_ELEM, with o_rd_addr = cycle-1.
  - Operand data arrive in cycles 2..N_ELEM+1.
  - Result register loads the same cycle data arrive. o_wr_en=1 in cycles 3..N_ELEM+2, with o_wr_addr = cycle-3.
  - o_done=1 in cycle N_ELEM+3; o_busy=1 in cycles 1..N_ELEM+3.
- Arithmetic, one registered stage:
  - Reduce each operand: x = in_1 >= 251 ? in_1-251 : in_1; y likewise from in_2. Inputs 0..255 are legal.
  - Compute d = {1'b0,x} - {1'b0,y} as 9 bits.
  - If d[8]=1 then result = d+251, else result = d. Register the low 8 bits into out.
  - Result is always canonical (0..250).
- Write address counter and read address counter are independent. Each saturates after N_ELEM-1; neither wraps within a run.
- When not writing, out holds its last value and o_wr_en=0.
- i_start while o_busy=1 (including the DONE cycle) is ignored; no restart, no state corruption.
- i_start in the cycle after DONE (back in IDLE) is accepted normally; back-to-back runs are legal.
- i_rst mid-run: on the next edge all outputs take reset values. No further rd/wr strobes. o_done is not pulsed for the aborted run.
- Simultaneous i_rst and i_start: reset wins; the start is dropped.
- N_ELEM=1: rd in cycle 1, wr in cycle 3, done in cycle 4.

Decomposition:
- Shared package/include: P251_Q = 251, P251_W = 8, and the FSM state encoding localparams (2-bit).
- One natural sub-module: p251_sub_core. It is a combinational 8-bit a-b mod 251 with operand pre-reduction, and is reusable alongside the adder.
- The top module holds the FSM, address counters, valid pipeline and output register.

Test Plan:
- N_ELEM=4 with in_1 = {5,3,0,250} and in_2 = {3,5,250,0} -> writes {2,249,1,250} at addrs 0..3 in cycles 3..6; o_done in cycle 7; o_busy in cycles 1..7.
- Non-canonical operands with in_1 = {255,0,251,254} and in_2 = {0,255,251,3} -> {4,247,0,0}.
- Pulse i_start at cycles 2 and 5 during a run -> exactly one run: 4 writes, one o_done; strobe timing unchanged.
- Assert i_rst at cycle 4 of an N_ELEM=4 run -> from cycle 5 all outputs are 0, no wr_en and no o_done. A new start at cycle 7 then runs a full, correct vector.
- N_ELEM=1 with in_1=0, in_2=1 -> out=250 with o_wr_en at cycle 3 and o_done at cycle 4. A back-to-back start at cycle 5 is accepted.
- Random 10k vectors with operands in 0..255 checked against a model of ((a mod 251) - (b mod 251) + 251) mod 251; every output is < 251.
